// File: rtl/jk_cmd_debounce_if.sv
// Button/command bundle between the raw push-buttons and the JK flip-flop.
// Latency: none, wires only.
// Backpressure: none; buttons are free-running levels and J/K are single-cycle pulses.
interface jk_cmd_debounce_if;
    logic btn_set;
    logic btn_clr;
    logic J;
    logic K;
    logic set_lvl;
    logic clr_lvl;
    logic pending;

    // Stimulus side: drives the raw buttons, observes commands and status.
    modport master (
        output btn_set,
        output btn_clr,
        input  J,
        input  K,
        input  set_lvl,
        input  clr_lvl,
        input  pending
    );

    // Command stage side.
    modport slave (
        input  btn_set,
        input  btn_clr,
        output J,
        output K,
        output set_lvl,
        output clr_lvl,
        output pending
    );
endinterface

// File: rtl/jk_cmd_debounce.sv
// Synchronise + debounce set/clear buttons, pair near-simultaneous presses into a J=K toggle pulse.
// Latency: 2 sync + DEBOUNCE_CYCLES to stable level; then 1 (unpaired/simultaneous/partner) or PAIR_WINDOW+1 cycles to J/K.
// Backpressure: none; J/K are single-cycle pulses, 0 otherwise. Optional auto-repeat: JK_CMD_AUTOREPEAT_EN.
module jk_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PAIR_WINDOW     = 8,
    parameter int REPEAT_CYCLES   = 64,
    parameter int CNT_W           = 8
) (
    input  logic            clk,
    input  logic            rst,
    jk_cmd_debounce_if.slave cmd
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_S = 2'd1;
    localparam logic [1:0] WAIT_C = 2'd2;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(PAIR_WINDOW);

    logic [1:0]       set_sync, clr_sync;
    logic [CNT_W-1:0] set_deb, clr_deb;
    logic             set_lvl, clr_lvl;
    logic             set_lvl_d, clr_lvl_d;
    logic             set_rise, clr_rise;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] win_cnt, win_nxt;
    logic             j_q, k_q, j_nxt, k_nxt;
    logic             rep_s_fire, rep_c_fire;

    // Two-flop synchronisers for the asynchronous buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_sync <= 2'b00;
            clr_sync <= 2'b00;
        end else begin
            set_sync <= {set_sync[0], cmd.btn_set};
            clr_sync <= {clr_sync[0], cmd.btn_clr};
        end
    end

    // Set channel debounce: flip the stable level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_deb <= '0;
            set_lvl <= 1'b0;
        end else if (set_sync[1] != set_lvl) begin
            if (set_deb == DEB_MAX) begin
                set_lvl <= set_sync[1];
                set_deb <= '0;
            end else begin
                set_deb <= set_deb + CNT_W'(1);
            end
        end else begin
            set_deb <= '0;
        end
    end

    // Clear channel debounce, identical to the set channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_deb <= '0;
            clr_lvl <= 1'b0;
        end else if (clr_sync[1] != clr_lvl) begin
            if (clr_deb == DEB_MAX) begin
                clr_lvl <= clr_sync[1];
                clr_deb <= '0;
            end else begin
                clr_deb <= clr_deb + CNT_W'(1);
            end
        end else begin
            clr_deb <= '0;
        end
    end

    // Delayed stable levels for press (0->1) edge detection; releases produce nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_lvl_d <= 1'b0;
            clr_lvl_d <= 1'b0;
        end else begin
            set_lvl_d <= set_lvl;
            clr_lvl_d <= clr_lvl;
        end
    end

    assign set_rise = set_lvl & ~set_lvl_d;
    assign clr_rise = clr_lvl & ~clr_lvl_d;

`ifdef JK_CMD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_s, rep_c, rep_s_nxt, rep_c_nxt;

    // Per-channel repeat timers run only in IDLE with the level held; a held pair shares the set timer's phase.
    always_comb begin
        rep_s_nxt  = '0;
        rep_c_nxt  = '0;
        rep_s_fire = 1'b0;
        rep_c_fire = 1'b0;
        if (state == IDLE && !set_rise && !clr_rise) begin
            if (set_lvl) begin
                if (rep_s == REP_MAX) rep_s_fire = 1'b1;
                else                  rep_s_nxt  = rep_s + CNT_W'(1);
            end
            if (clr_lvl) begin
                if (rep_c == REP_MAX) rep_c_fire = 1'b1;
                else                  rep_c_nxt  = rep_c + CNT_W'(1);
            end
            if (set_lvl && clr_lvl) begin
                rep_c_nxt  = rep_s_nxt;
                rep_c_fire = rep_s_fire;
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_s <= '0;
            rep_c <= '0;
        end else begin
            rep_s <= rep_s_nxt;
            rep_c <= rep_c_nxt;
        end
    end
`else
    logic unused_rep;
    assign unused_rep = (REPEAT_CYCLES > 0);
    assign rep_s_fire = 1'b0;
    assign rep_c_fire = 1'b0;
`endif

    // Pairing FSM: a lone press waits PAIR_WINDOW cycles for its partner before issuing its own command.
    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (set_rise && clr_rise) begin
                    j_nxt = 1'b1;
                    k_nxt = 1'b1;
                end else if (set_rise) begin
                    if (PAIR_WINDOW == 0) begin
                        j_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_S;
                        win_nxt   = WIN_LOAD;
                    end
                end else if (clr_rise) begin
                    if (PAIR_WINDOW == 0) begin
                        k_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT_C;
                        win_nxt   = WIN_LOAD;
                    end
                end
            end
            WAIT_S: begin
                // The window is reaching 0 on this edge when it holds 1.
                if (clr_rise || win_cnt <= CNT_W'(1)) begin
                    j_nxt     = 1'b1;
                    k_nxt     = clr_rise;
                    state_nxt = IDLE;
                    win_nxt   = '0;
                end else begin
                    win_nxt = win_cnt - CNT_W'(1);
                end
            end
            WAIT_C: begin
                if (set_rise || win_cnt <= CNT_W'(1)) begin
                    j_nxt     = set_rise;
                    k_nxt     = 1'b1;
                    state_nxt = IDLE;
                    win_nxt   = '0;
                end else begin
                    win_nxt = win_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                win_nxt   = '0;
            end
        endcase
        j_nxt = j_nxt | rep_s_fire;
        k_nxt = k_nxt | rep_c_fire;
    end

    // FSM state, window counter and registered command pulses; reset discards any pending command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win_cnt <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_nxt;
            j_q     <= j_nxt;
            k_q     <= k_nxt;
        end
    end

    assign cmd.J       = j_q;
    assign cmd.K       = k_q;
    assign cmd.set_lvl = set_lvl;
    assign cmd.clr_lvl = clr_lvl;
    assign cmd.pending = (state == WAIT_S) || (state == WAIT_C);
endmodule

// File: tb/tb_jk_cmd_debounce.sv
// Directed bench for jk_cmd_debounce with DEBOUNCE_CYCLES=16, PAIR_WINDOW=8, REPEAT_CYCLES=64.
// Inputs change and outputs are sampled on the falling edge; cycle i = i-th falling edge after the change.
// Observed vector packs {J, K, set_lvl, clr_lvl, pending}.
module tb_jk_cmd_debounce;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [4:0] obs, exp_v;

    jk_cmd_debounce_if bus ();

    jk_cmd_debounce #(
        .DEBOUNCE_CYCLES(16),
        .PAIR_WINDOW    (8),
        .REPEAT_CYCLES  (64),
        .CNT_W          (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd(bus)
    );

    always #5 clk = ~clk;

    always_comb obs = {bus.J, bus.K, bus.set_lvl, bus.clr_lvl, bus.pending};

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_set = 1'b0;
        bus.btn_clr = 1'b0;
        #1;
        vectors++;
        if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_async: got %b want 00000", obs);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: got %b want 00000", i, obs);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_glitch();
        bus.btn_set = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 5'b00000) begin
                miscompares++;
                $display("FAIL glitch cyc %0d: got %b want 00000", i, obs);
            end
            if (i == 10) bus.btn_set = 1'b0;
        end
    endtask

    task automatic test_single_press();
        bus.btn_set = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            exp_v = {i == 27, 1'b0, i >= 18, 1'b0, (i >= 19 && i <= 26)};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL single_press cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
        bus.btn_set = 1'b0;
        for (int i = 41; i <= 70; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'b0, i < 58, 1'b0, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL single_release cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_pair();
        bus.btn_set = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            exp_v = {i == 23, i == 23, i >= 18, i >= 22, (i >= 19 && i <= 22)};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pair cyc %0d: got %b want %b", i, obs, exp_v);
            end
            if (i == 4) bus.btn_clr = 1'b1;
        end
        bus.btn_set = 1'b0;
        bus.btn_clr = 1'b0;
        for (int i = 41; i <= 70; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'b0, i < 58, i < 58, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pair_release cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        bus.btn_set = 1'b1;
        bus.btn_clr = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            exp_v = {i == 19, i == 19, i >= 18, i >= 18, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL simultaneous cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
        bus.btn_set = 1'b0;
        bus.btn_clr = 1'b0;
        for (int i = 31; i <= 60; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'b0, i < 48, i < 48, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL simultaneous_release cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        bus.btn_set = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'b0, i >= 18, 1'b0, (i >= 19)};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL mid_window_pre cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
        rst = 1'b1;
        bus.btn_set = 1'b0;
        #1;
        vectors++;
        if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL mid_window_reset: got %b want 00000", obs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 5'b00000) begin
                miscompares++;
                $display("FAIL mid_window_after cyc %0d: got %b want 00000", i, obs);
            end
        end
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1;
        bus.btn_clr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL held_in_reset: got %b want 00000", obs);
        end
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            exp_v = {1'b0, i == 27, 1'b0, i >= 18, (i >= 19 && i <= 26)};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL held_through_reset cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
        bus.btn_clr = 1'b0;
        for (int i = 41; i <= 70; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'b0, 1'b0, i < 58, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL held_release cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

`ifdef JK_CMD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        bus.btn_clr = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            exp_v = {1'b0, (i >= 27 && ((i - 27) % 64) == 0), 1'b0, i >= 18, (i >= 19 && i <= 26)};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL autorepeat cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
        bus.btn_clr = 1'b0;
        for (int i = 301; i <= 340; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'b0, 1'b0, i < 318, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL autorepeat_release cyc %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        @(negedge clk);
        test_glitch();
        test_single_press();
        test_pair();
        test_simultaneous();
        test_reset_mid_window();
        test_held_through_reset();
`ifdef JK_CMD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jk_cmd_debounce.md
# jk_cmd_debounce

Front-end command stage for the JK flip-flop. It conditions two raw, asynchronous push-button inputs: a set button and a clear button. Each input is synchronised and debounced, and each debounced press becomes a single-cycle J pulse, K pulse or J=K toggle pulse. The J/K outputs connect directly to the flip-flop's J/K inputs. Between pulses both outputs are 0, which holds the flip-flop's state.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a level change; minimum 2.
- PAIR_WINDOW, 8: cycles to wait for the second button so the pair emits a toggle; 0 disables pairing.
- REPEAT_CYCLES, 64: auto-repeat period in cycles while a button is held; used only with the repeat macro.
- CNT_W, 8: width of the internal counters; must hold max(DEBOUNCE_CYCLES, PAIR_WINDOW, REPEAT_CYCLES).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- btn_set  in  1  raw set button, asynchronous, active-high.
- btn_clr  in  1  raw clear button, asynchronous, active-high.
- J  out  1  registered single-cycle set command.
- K  out  1  registered single-cycle clear command.
- set_lvl  out  1  debounced level of btn_set.
- clr_lvl  out  1  debounced level of btn_clr.
- pending  out  1  high while the pairing window is open.

## Operation
- Each input passes through a 2-flop synchroniser.
- Per channel, a debounce counter counts cycles in which the synced value differs from the stable level. It clears to 0 on any match.
- When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the stable level flips and the counter clears.
- A 0→1 transition of the stable level produces a one-cycle rise event. Release (1→0) produces no command.
- FSM states: IDLE, WAIT_S (set seen first), WAIT_C (clear seen first).
  - IDLE, both rise events in the same cycle: J=K=1 next cycle; stay in IDLE.
  - IDLE, set rise only: with PAIR_WINDOW=0, J=1 next cycle. Otherwise go to WAIT_S and load the window counter with PAIR_WINDOW.
  - IDLE, clear rise only: mirror of the set case, using K and WAIT_C.
  - WAIT_S, clear rise: J=K=1 next cycle; go to IDLE.
  - WAIT_S, window counter reaches 0: J=1 next cycle; go to IDLE.
  - WAIT_C: mirror of WAIT_S.
  - WAIT_x, a repeated rise on the same channel: ignored; the window is not restarted.
- pending=1 in WAIT_S and WAIT_C, otherwise 0.
- J and K are never high for more than 1 consecutive cycle.

## Timing
- Reset values: J=0, K=0, set_lvl=0, clr_lvl=0, pending=0. Synchronisers and counters are 0; FSM is in IDLE.
- A button held through reset debounces in afresh after reset and produces one press.
- Raw edge to stable-level change: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles.
- Any glitch shorter than DEBOUNCE_CYCLES synced cycles is rejected.
- Stable-level rise to command pulse:
  - 1 cycle when unpaired (PAIR_WINDOW=0) or on a simultaneous rise.
  - PAIR_WINDOW+1 cycles on window expiry.
  - 1 cycle after the partner rise when pairing.
- Reset asserted mid-window: the pending command is discarded; no pulse is emitted.

## Configuration
- JK_CMD_AUTOREPEAT_EN defined:
  - In IDLE, while a stable level stays high, a per-channel repeat counter counts.
  - Every REPEAT_CYCLES cycles it emits a repeat pulse for that button (J for set, K for clear), bypassing pairing.
  - If both levels are held, their repeat counters are aligned and emit J=K=1 together.
  - The repeat counter clears on release or reset.
- JK_CMD_AUTOREPEAT_EN not defined: exactly one command per press. The repeat logic is absent.

## Test plan
- DEBOUNCE_CYCLES=16, PAIR_WINDOW=8; btn_set glitch of 10 cycles -> set_lvl stays 0; J stays 0.
- btn_set held 40 cycles -> set_lvl rises 18 cycles after the raw edge; exactly one J pulse 9 cycles later; K=0 throughout.
- btn_set, then btn_clr 4 cycles later, both held -> pending=1 for 4 cycles; single J=K=1 pulse; no separate J or K pulse.
- Both buttons rise in the same cycle -> J=K=1 one cycle after the stable rise; pending never asserts.
- rst asserted while pending=1 -> all outputs 0 immediately; no pulse after release with buttons low.
- With JK_CMD_AUTOREPEAT_EN, REPEAT_CYCLES=64, btn_clr held 300 cycles -> initial K pulse, then K pulses every 64 cycles; pulses stop on release.
